// File: rtl/counter_nbit.sv
// Up/down modulo counter with a clock-enable prescaler, synchronous clamped load and tc/step pulses.
// Optional build macro COUNTER_SATURATE_EN makes the counter clamp at the ends instead of wrapping.
module counter_nbit #(
    parameter int unsigned     WIDTH    = 8,
    parameter int unsigned     PRESCALE = 4194304,
    parameter longint unsigned MODULUS  = 256
) (
    input  logic             clk,
    input  logic             rst_on,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             step
);

    localparam int unsigned    PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  P_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [PW-1:0]    pcnt_r;
    logic [PW-1:0]    pcnt_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             step_r;
    logic             step_nxt_s;
    logic             step_edge_s;
    logic             at_end_s;

    assign step_edge_s = en && (pcnt_r == P_MAX);
    assign at_end_s    = up ? (count_r == C_MAX) : (count_r == {WIDTH{1'b0}});

    // Next-state: load beats stepping; an end-of-range step either wraps or clamps.
    always_comb begin
        pcnt_nxt_s  = pcnt_r;
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        step_nxt_s  = 1'b0;
        if (load) begin
            pcnt_nxt_s  = {PW{1'b0}};
            if (64'(load_val) >= MODULUS) begin
                count_nxt_s = C_MAX;
            end else begin
                count_nxt_s = load_val;
            end
        end else if (step_edge_s) begin
            pcnt_nxt_s = {PW{1'b0}};
            step_nxt_s = 1'b1;
            if (at_end_s) begin
                tc_nxt_s = 1'b1;
`ifdef COUNTER_SATURATE_EN
                count_nxt_s = count_r;
`else
                count_nxt_s = up ? {WIDTH{1'b0}} : C_MAX;
`endif
            end else if (up) begin
                count_nxt_s = count_r + WIDTH'(1);
            end else begin
                count_nxt_s = count_r - WIDTH'(1);
            end
        end else if (en) begin
            pcnt_nxt_s = pcnt_r + PW'(1);
        end else begin
            pcnt_nxt_s = pcnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst_on) begin
        if (rst_on) begin
            pcnt_r  <= {PW{1'b0}};
            count_r <= {WIDTH{1'b0}};
            tc_r    <= 1'b0;
            step_r  <= 1'b0;
        end else begin
            pcnt_r  <= pcnt_nxt_s;
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign step  = step_r;

endmodule

// File: tb/tb_counter_nbit.sv
// Randomized self-checking bench for counter_nbit against an arithmetic reference model.
// A second instance (PRESCALE=1, WIDTH=8, MODULUS=256) covers the full-range single-cycle step case.
module tb_counter_nbit;

    localparam int P = 3;
    localparam int M = 10;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_on = 1'b1;
    logic       en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic       tc, step;

    logic       en_b = 1'b0;
    logic [7:0] count_b;
    logic       tc_b, step_b;
    logic [7:0] zero8 = 8'd0;
    logic       zero1 = 1'b0;
    logic       one1 = 1'b1;

    int total_cnt = 0;
    int bad_cnt   = 0;

    int m_cnt = 0, m_pc = 0, m_tc = 0, m_step = 0;

    always #5 clk = ~clk;

    counter_nbit #(.WIDTH(4), .PRESCALE(3), .MODULUS(10)) dut (
        .clk(clk), .rst_on(rst_on), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .step(step)
    );

    counter_nbit #(.WIDTH(8), .PRESCALE(1), .MODULUS(256)) dut_b (
        .clk(clk), .rst_on(rst_on), .en(en_b), .up(one1), .load(zero1),
        .load_val(zero8), .count(count_b), .tc(tc_b), .step(step_b)
    );

    task automatic check_value(input string tag, input longint obs, input longint exp);
        total_cnt++;
        if (obs != exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pc = 0; m_tc = 0; m_step = 0;
    endtask

    // Reference behaviour of one clock edge from the current inputs.
    task automatic model_edge();
        int lv;
        bit wrap;
        lv = int'(load_val);
        if (load) begin
            m_cnt  = (lv >= M) ? M - 1 : lv;
            m_pc   = 0;
            m_tc   = 0;
            m_step = 0;
        end else if (en && m_pc == P - 1) begin
            m_pc   = 0;
            m_step = 1;
            wrap   = up ? (m_cnt == M - 1) : (m_cnt == 0);
            m_tc   = wrap ? 1 : 0;
            if (!(SAT && wrap))
                m_cnt = up ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
        end else begin
            if (en) m_pc = m_pc + 1;
            m_tc   = 0;
            m_step = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_value("count", longint'(count), longint'(m_cnt));
        check_value("tc", longint'(tc), longint'(m_tc));
        check_value("step", longint'(step), longint'(m_step));
    endtask

    initial begin
        int steps_seen, tc_seen, n, tcb_seen;

        // reset state
        #3;
        check_value("rst_count", longint'(count), 0);
        check_value("rst_tc", longint'(tc), 0);
        check_value("rst_step", longint'(step), 0);
        @(posedge clk);
        #1;
        rst_on = 1'b0;
        model_reset();

        // free run upward for 33 cycles
        en = 1'b1; up = 1'b1;
        steps_seen = 0; tc_seen = 0;
        for (int i = 0; i < 33; i++) begin
            tick();
            steps_seen += int'(step);
            tc_seen    += int'(tc);
        end
        check_value("run33_steps", longint'(steps_seen), 11);
        check_value("run33_tcs", longint'(tc_seen), SAT ? 2 : 1);

        // count down through zero
        load = 1'b1; load_val = 4'd0; tick();
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_value("down_end", longint'(count), SAT ? 0 : 7);

        // out-of-range load clamps
        load = 1'b1; load_val = 4'd13; tick();
        load = 1'b0;
        check_value("load13", longint'(count), 9);

        // load coinciding with a step edge
        up = 1'b1;
        n = 0;
        while (m_pc != P - 1 && n < 10) begin tick(); n++; end
        load = 1'b1; load_val = 4'd4; tick();
        load = 1'b0;
        check_value("load_on_step_cnt", longint'(count), 4);
        check_value("load_on_step_stp", longint'(step), 0);

        // en low for 5 cycles stretches the step interval to 8
        n = 0;
        while (step !== 1'b1 && n < 10) begin tick(); n++; end
        n = 0;
        do begin
            n++;
            en = (n >= 2 && n <= 6) ? 1'b0 : 1'b1;
            tick();
        end while (step !== 1'b1 && n < 20);
        en = 1'b1;
        check_value("stretch_interval", longint'(n), 8);

        // saturation/wrap ends: up from 8, down from 0
        load = 1'b1; load_val = 4'd8; tick();
        load = 1'b0; up = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        load = 1'b1; load_val = 4'd0; tick();
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            load = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick();
        end
        load = 1'b0; en = 1'b1; up = 1'b1;

        // asynchronous reset right after a step pulse
        load = 1'b1; load_val = 4'd5; tick();
        load = 1'b0;
        n = 0;
        while (m_step != 1 && n < 10) begin tick(); n++; end
        #1 rst_on = 1'b1;
        #1;
        check_value("arst_count", longint'(count), 0);
        check_value("arst_tc", longint'(tc), 0);
        check_value("arst_step", longint'(step), 0);
        @(posedge clk);
        #1 rst_on = 1'b0;
        model_reset();
        for (int i = 0; i < 7; i++) tick();

        // PRESCALE=1 full-range run on the second instance
        en = 1'b0;
        en_b = 1'b1;
        tcb_seen = 0;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            check_value("b_count", longint'(count_b), longint'(k % 256));
            check_value("b_step", longint'(step_b), 1);
            tcb_seen += int'(tc_b);
        end
        en_b = 1'b0;
        check_value("b_tc_total", longint'(tcb_seen), 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/counter_nbit.md
# counter_nbit

Parametrised up/down counter with an internal single-clock prescaler, synchronous load, programmable modulus and a terminal-count pulse. It is the general-purpose successor to the fixed 8-bit free-running counter. It is fully synchronous to `clk`: the prescaler produces a clock-enable, not a divided clock. `count` feeds the LED bank and the seven-segment drawer directly.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; legal range 1..32.
- `PRESCALE`, 4194304: `clk` cycles per count step; must be ≥1.
- `MODULUS`, 256: count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- `clk`  in  1  system clock.
- `rst_on`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable; low freezes both the prescaler and the counter.
- `up`  in  1  direction: 1 counts up, 0 counts down; sampled on step cycles.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `count`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal-count pulse, one `clk` cycle wide.
- `step`  out  1  pulse, one `clk` cycle wide, asserted after each count update.

## Operation
- Prescaler `pcnt` runs 0..PRESCALE-1. A step edge is a rising `clk` edge with `en`=1 and `pcnt`=PRESCALE-1.
- On a step edge, `pcnt` goes to 0. On other `en`=1 edges, `pcnt` increments by 1. When `en`=0, `pcnt` holds.
- With PRESCALE=1, every `en`=1 edge is a step edge.
- Step behaviour when `up`=1:
  - If count < MODULUS-1, count increments.
  - If count = MODULUS-1, count wraps to 0 and `tc` is set.
- Step behaviour when `up`=0:
  - If count > 0, count decrements.
  - If count = 0, count wraps to MODULUS-1 and `tc` is set.
- `step` is registered high on every step edge, including wrap steps.
- Load has priority over stepping. On any edge with `load`=1, independent of `en`:
  - count takes `load_val`. If `load_val` ≥ MODULUS, count takes MODULUS-1 instead.
  - `pcnt` is cleared to 0.
  - `tc` and `step` are both 0 on the next cycle.
- All arithmetic is modulo MODULUS, never modulo 2^WIDTH. `count` never holds a value ≥ MODULUS.
- Reset mid-operation clears everything immediately, with no pending step or pulse afterwards.

## Timing
- Reset values: `count`=0, `pcnt`=0, `tc`=0, `step`=0.
- Latency:
  - `count`, `tc` and `step` all change on the same step edge and are visible in the following cycle.
  - `tc` and `step` drop after exactly one cycle.
- Enabled step period is exactly PRESCALE cycles. Toggling `en` stretches the period by the number of disabled cycles and loses no prescaler progress.
- A direction change takes effect on the next step edge.
- Edge combinations:
  - `load` and a step edge coinciding: the load wins, and that step is discarded.
  - `en` falling on the step edge itself: no step, and `pcnt` holds at PRESCALE-1.
  - Reset deasserting: first step occurs PRESCALE enabled cycles later.

## Configuration
- `COUNTER_SATURATE_EN` defined:
  - Counter clamps at the ends instead of wrapping.
  - A step at MODULUS-1 (up) or at 0 (down) leaves count unchanged, still pulses `tc`, and still pulses `step`.
- `COUNTER_SATURATE_EN` undefined: wrap behaviour as above. This is the default build.

## Test plan
Bench parameters: WIDTH=4, MODULUS=10, PRESCALE=3.
- Release reset, `en`=1, `up`=1 for 33 cycles -> count steps every 3 cycles: 0,1,…,9,0. `tc` is high only in the cycle after the 9→0 step. `step` pulses 11 times.
- `up`=0 from count=0 -> next step gives count=9 with `tc`=1. Subsequent steps give 8, 7.
- `load`=1 with `load_val`=13 -> count=9 next cycle, `pcnt`=0. `load` coinciding with a step edge with `load_val`=4 -> count=4, no `tc`, no `step`.
- `en` low for 5 cycles between steps -> step interval measures 8 cycles and count is otherwise unchanged. Assert `rst_on` mid-prescale -> count=0 and `tc`/`step`=0 asynchronously, before the next `clk` edge.
- With `COUNTER_SATURATE_EN`: count up from 8 -> 9, then 9 held; `tc` pulses on each held step. Count down from 0 -> stays 0 with `tc` pulse.
- PRESCALE=1, WIDTH=8, MODULUS=256, `up`=1 for 256 cycles -> count returns to 0, `tc` pulses exactly once, `step` is high every cycle.
